// File: rtl/arbiter_rr4_pkg.sv
// Shared definitions for the four-requester round-robin arbiter:
// FSM state encoding, requester count and owner-index width.
package arbiter_rr4_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/arbiter_rr4_if.sv
// Request/grant bundle between the requesting blocks and the arbiter.
// master = requester side (drives en/req), slave = arbiter side.
interface arbiter_rr4_if;

    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    modport master (
        output en, req,
        input  gnt, gnt_idx, gnt_valid, preempt
    );

    modport slave (
        input  en, req,
        output gnt, gnt_idx, gnt_valid, preempt
    );

endinterface

// File: rtl/arbiter_rr4_rr_pick4.sv
// Combinational round-robin search: scans cand starting at (last+1) mod 4,
// wrapping 3->0, and returns the first set bit. last itself is checked last.
module rr_pick4
    import arbiter_rr4_pkg::*;
(
    input  logic [NUM_REQ-1:0] cand,
    input  logic [IDX_W-1:0]   last,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] pos;

    // First candidate after the pointer wins; 2-bit add gives the wrap.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            pos = last + IDX_W'(i);
            if (!found && cand[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/arbiter_rr4.sv
// Four-requester round-robin arbiter with registered grants.
// A grant is held until its owner drops req; on release the next pending
// requester in round-robin order is granted at the same edge (no bubble).
// Optional build macro ARB_TIMEOUT_EN adds a hold counter that forces a
// hand-off after MAX_HOLD cycles when another requester is waiting.
module arbiter_rr4
    import arbiter_rr4_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CW       = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    arbiter_rr4_if.slave arb
);

    if (MAX_HOLD < 2 || MAX_HOLD >= (1 << CW)) begin : g_bad_cfg
        $error("arbiter_rr4: MAX_HOLD must be in 2..2**CW-1");
    end

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [NUM_REQ-1:0] owner_oh;
    logic [NUM_REQ-1:0] cand;
    logic [IDX_W-1:0]   pick_last;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;

`ifdef ARB_TIMEOUT_EN
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               pre_q, pre_d;
`endif

    // Build the search input: while granted, the owner is excluded and the
    // search starts just past it, so a re-request by the owner ranks last.
    always_comb begin
        owner_oh = NUM_REQ'(1) << idx_q;
        if (state_q == ST_GRANT) begin
            cand      = arb.req & ~owner_oh;
            pick_last = idx_q;
        end else begin
            cand      = arb.req;
            pick_last = last_q;
        end
    end

    rr_pick4 u_pick (
        .cand  (cand),
        .last  (pick_last),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // State register: FSM state, owner index, round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
            pre_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
`endif
        end
    end

    // Next-state logic: grant from idle, hold, hand-off or return to idle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        pre_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arb.en && pick_found) begin
                    state_d = ST_GRANT;
                    idx_d   = pick_idx;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_GRANT: begin
                if (!arb.req[idx_q]) begin
                    last_d = idx_q;
                    if (arb.en && pick_found) begin
                        idx_d = pick_idx;
`ifdef ARB_TIMEOUT_EN
                        cnt_d = '0;
`endif
                    end else begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == HOLD_LAST) begin
                    if (arb.en && pick_found) begin
                        last_d = idx_q;
                        idx_d  = pick_idx;
                        cnt_d  = '0;
                        pre_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Outputs decode purely from registers, so they change only at edges.
    always_comb begin
        arb.gnt_valid = (state_q == ST_GRANT);
        arb.gnt_idx   = idx_q;
        arb.gnt       = (state_q == ST_GRANT) ? (NUM_REQ'(1) << idx_q) : '0;
`ifdef ARB_TIMEOUT_EN
        arb.preempt   = pre_q;
`else
        arb.preempt   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_arbiter_rr4.sv
// Directed testbench for arbiter_rr4: reset values, first grant, round-robin
// rotation, en blocking, release with simultaneous requests, asynchronous
// reset mid-grant, and the ARB_TIMEOUT_EN forced release (MAX_HOLD=4).
module tb_arbiter_rr4;

    logic clk = 1'b0;
    logic reset_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    arbiter_rr4_if bus ();

    arbiter_rr4 #(.MAX_HOLD(4), .CW(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .arb     (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.en  = 1'b0;
        bus.req = 4'b0000;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.en  = 1'b0;
        bus.req = 4'b0000;
        #1;
        n_cmp++;
        if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
        n_cmp++;
        if (bus.gnt_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", bus.gnt_idx); end
        n_cmp++;
        if (bus.gnt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.gnt_valid); end
        n_cmp++;
        if (bus.preempt !== 1'b0) begin n_fail++; $display("FAIL reset_preempt: got %b want 0", bus.preempt); end
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_first_grant();
        bus.en  = 1'b1;
        bus.req = 4'b0001;
        tick();
        n_cmp++;
        if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL first_gnt: got %b want 0001", bus.gnt); end
        n_cmp++;
        if (bus.gnt_idx !== 2'd0) begin n_fail++; $display("FAIL first_idx: got %0d want 0", bus.gnt_idx); end
        n_cmp++;
        if (bus.gnt_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b want 1", bus.gnt_valid); end
        bus.req = 4'b0000;
        tick();
        n_cmp++;
        if (bus.gnt_valid !== 1'b0 || bus.gnt !== 4'b0000) begin
            n_fail++; $display("FAIL first_release: got gnt=%b valid=%b want 0000/0", bus.gnt, bus.gnt_valid);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] want;
        do_reset();
        bus.en  = 1'b1;
        bus.req = 4'b1111;
        tick();
        for (int k = 0; k < 4; k++) begin
            want = 4'b0001 << k;
            repeat (2) begin
                tick();
                n_cmp++;
                if (bus.gnt !== want) begin n_fail++; $display("FAIL rot_hold%0d: got %b want %b", k, bus.gnt, want); end
            end
            bus.req = 4'b1111 & ~want;
            tick();
            bus.req = 4'b1111;
            want = 4'b0001 << ((k + 1) % 4);
            n_cmp++;
            if (bus.gnt !== want || bus.gnt_valid !== 1'b1) begin
                n_fail++; $display("FAIL rot_next%0d: got gnt=%b valid=%b want %b/1", k, bus.gnt, bus.gnt_valid, want);
            end
        end
        n_cmp++;
        if (bus.gnt_idx !== 2'd0) begin n_fail++; $display("FAIL rot_wrap_idx: got %0d want 0", bus.gnt_idx); end
    endtask

    task automatic test_en_block();
        do_reset();
        bus.en  = 1'b1;
        bus.req = 4'b0100;
        tick();
        n_cmp++;
        if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL en_own2: got %b want 0100", bus.gnt); end
        bus.en  = 1'b0;
        bus.req = 4'b0101;
        tick();
        n_cmp++;
        if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL en_hold: got %b want 0100", bus.gnt); end
        bus.req = 4'b0001;
        tick();
        n_cmp++;
        if (bus.gnt !== 4'b0000 || bus.gnt_valid !== 1'b0) begin
            n_fail++; $display("FAIL en_release: got gnt=%b valid=%b want 0000/0", bus.gnt, bus.gnt_valid);
        end
        tick();
        n_cmp++;
        if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL en_blocked: got %b want 0000", bus.gnt); end
        bus.en = 1'b1;
        tick();
        n_cmp++;
        if (bus.gnt !== 4'b0001 || bus.gnt_idx !== 2'd0) begin
            n_fail++; $display("FAIL en_resume: got gnt=%b idx=%0d want 0001/0", bus.gnt, bus.gnt_idx);
        end
    endtask

    task automatic test_simul_release();
        do_reset();
        bus.en  = 1'b1;
        bus.req = 4'b0010;
        tick();
        n_cmp++;
        if (bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL sim_own1: got %b want 0010", bus.gnt); end
        // Owner 1 drops as 0 and 3 arrive: search starts at 2, so 3 wins.
        bus.req = 4'b1001;
        tick();
        n_cmp++;
        if (bus.gnt !== 4'b1000 || bus.gnt_idx !== 2'd3) begin
            n_fail++; $display("FAIL sim_next3: got gnt=%b idx=%0d want 1000/3", bus.gnt, bus.gnt_idx);
        end
        bus.req = 4'b1010;
        tick();
        n_cmp++;
        if (bus.gnt !== 4'b1000) begin n_fail++; $display("FAIL sim_hold3: got %b want 1000", bus.gnt); end
        // Owner 3 drops with 0 and 1 pending: search starts at 0.
        bus.req = 4'b0011;
        tick();
        n_cmp++;
        if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL sim_next0: got %b want 0001", bus.gnt); end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.en  = 1'b1;
        bus.req = 4'b0100;
        tick();
        n_cmp++;
        if (bus.gnt_idx !== 2'd2) begin n_fail++; $display("FAIL arst_pre_idx: got %0d want 2", bus.gnt_idx); end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.gnt !== 4'b0000 || bus.gnt_valid !== 1'b0 || bus.gnt_idx !== 2'd0) begin
            n_fail++; $display("FAIL arst_clear: got gnt=%b valid=%b idx=%0d want 0000/0/0", bus.gnt, bus.gnt_valid, bus.gnt_idx);
        end
        #3;
        reset_n = 1'b1;
        bus.req = 4'b1000;
        tick();
        tick();
        n_cmp++;
        if (bus.gnt !== 4'b1000) begin n_fail++; $display("FAIL arst_regrant: got %b want 1000", bus.gnt); end
    endtask

    task automatic test_timeout();
        do_reset();
        bus.en  = 1'b1;
        bus.req = 4'b0001;
        tick();
        bus.req = 4'b0101;
`ifdef ARB_TIMEOUT_EN
        for (int c = 1; c <= 3; c++) begin
            tick();
            n_cmp++;
            if (bus.gnt !== 4'b0001 || bus.preempt !== 1'b0) begin
                n_fail++; $display("FAIL to_hold%0d: got gnt=%b pre=%b want 0001/0", c, bus.gnt, bus.preempt);
            end
        end
        tick();
        n_cmp++;
        if (bus.gnt !== 4'b0100 || bus.preempt !== 1'b1) begin
            n_fail++; $display("FAIL to_force: got gnt=%b pre=%b want 0100/1", bus.gnt, bus.preempt);
        end
        tick();
        n_cmp++;
        if (bus.gnt !== 4'b0100 || bus.preempt !== 1'b0) begin
            n_fail++; $display("FAIL to_pulse_end: got gnt=%b pre=%b want 0100/0", bus.gnt, bus.preempt);
        end
        do_reset();
        bus.en  = 1'b1;
        bus.req = 4'b0001;
        tick();
        for (int c = 0; c < 8; c++) begin
            tick();
            n_cmp++;
            if (bus.gnt !== 4'b0001 || bus.preempt !== 1'b0) begin
                n_fail++; $display("FAIL to_alone%0d: got gnt=%b pre=%b want 0001/0", c, bus.gnt, bus.preempt);
            end
        end
`else
        for (int c = 0; c < 8; c++) begin
            tick();
            n_cmp++;
            if (bus.gnt !== 4'b0001 || bus.preempt !== 1'b0) begin
                n_fail++; $display("FAIL nto_hold%0d: got gnt=%b pre=%b want 0001/0", c, bus.gnt, bus.preempt);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_first_grant();
        test_rotation();
        test_en_block();
        test_simul_release();
        test_async_reset();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
